cycle_sequencer: RTL

- Front-end timing stage directly upstream of the instruction decoder.
- Holds the instruction register and the T-state cycle counter; these drive the decoder's inst and cycle inputs.
- Latches and prioritises reset/NMI/IRQ requests, which feed the decoder's clr/nmi/irq inputs.
- Consumes the decoder's icyc/rcyc/scyc sequencing strobes and forces the interrupt opcode into the instruction register when a request is pending at an instruction boundary.

---
 rtl/cycle_sequencer.sv | 61 ++++++
 1 files changed

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: instruction register, T-state counter and reset/NMI/IRQ request latching for the decoder
module cycle_sequencer #(
  parameter logic [7:0]       INT_OP   = 8'h00,
  parameter int               CYC_W    = 3,
  parameter logic [CYC_W-1:0] SCYC_TGT = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       dbus,
  input  logic             icyc,
  input  logic             rcyc,
  input  logic             scyc,
  input  logic             irq,
  input  logic             nmi,
  input  logic             imask,
  output logic [7:0]       inst,
  output logic [CYC_W-1:0] cycle,
  output logic             rstreq,
  output logic             nmireq,
  output logic             irqreq,
  output logic             sync
);
  logic rst_p, nmi_p, irq_s, nmi_d;
  logic nmi_edge, retire, any_req;
  logic [7:0] inst_n;
  logic [CYC_W-1:0] cycle_n;
  logic rst_p_n, nmi_p_n;
  always_comb begin
    rstreq   = rst_p;
    nmireq   = nmi_p & ~rst_p;
    irqreq   = irq_s & ~imask & ~rst_p & ~nmi_p;
    sync     = cycle == '0;
    nmi_edge = nmi & ~nmi_d;
    retire   = scyc & sync;
    any_req  = rstreq | nmireq | irqreq;
  end
  // A new NMI edge beats retirement of the one being serviced, so it is not lost
  always_comb begin
    cycle_n = rcyc ? '0 : scyc ? SCYC_TGT : icyc ? cycle + 1'b1 : cycle;
    inst_n  = rcyc ? (any_req ? INT_OP : dbus) : inst;
    rst_p_n = rst_p & ~retire;
    nmi_p_n = nmi_edge | (nmi_p & ~(retire & ~rst_p));
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      inst  <= INT_OP;
      cycle <= '0;
      rst_p <= 1'b1;
      nmi_p <= 1'b0;
      irq_s <= 1'b0;
      nmi_d <= 1'b0;
    end else begin
      inst  <= inst_n;
      cycle <= cycle_n;
      rst_p <= rst_p_n;
      nmi_p <= nmi_p_n;
      irq_s <= irq;
      nmi_d <= nmi;
    end
  end
endmodule
